// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI mode-0 master for single-byte read/write frames to a
// spiMemory-style slave. Frame = {addr, rw, data}, shifted out MSB first.
// All pins are registered copies of the FSM state, so they lag the state by one clk.
// Optional build macro: SPI_MASTER_MISO_SYNC_EN adds a 2-flop miso synchroniser
// and moves the capture point 2 clk later within the sclk high phase (CLK_DIV >= 3).
module spi_mem_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  localparam int FRAME = ADDR_W + 1 + DATA_W;
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(FRAME);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
  localparam logic [BIT_W-1:0] DATA_FIRST = BIT_W'(ADDR_W + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, DONE, GAP} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic               phase_reg, phase_next;   // 0 = sclk low half, 1 = high half
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic [FRAME-1:0]   frame_reg, frame_next;
  logic               rw_reg, rw_next;
  logic [DATA_W-1:0]  rdata_reg;
  logic               cap_now;

  // Ready is combinational so it drops together with reset and rises on the first cycle after it.
  assign cmd_ready = (state_reg == IDLE) && !reset;

  // Strobe for the cycle in which sclk_pin is high for the first time during a data bit.
  assign cap_now = (state_reg == SHIFT) && phase_reg && (div_reg == DIV_W'(1)) &&
                   (bit_reg >= DATA_FIRST);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      phase_reg <= 1'b0;
      bit_reg   <= '0;
      frame_reg <= '0;
      rw_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      phase_reg <= phase_next;
      bit_reg   <= bit_next;
      frame_reg <= frame_next;
      rw_reg    <= rw_next;
    end
  end

  // Next-state logic: latch the frame on accept, then time each half bit with div_reg.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    frame_next = frame_reg;
    rw_next    = rw_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          frame_next = {cmd_addr, cmd_rw, (cmd_rw ? DATA_W'(0) : cmd_wdata)};
          rw_next    = cmd_rw;
          div_next   = '0;
          phase_next = 1'b0;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!phase_reg) begin
            phase_next = 1'b1;
          end else begin
            phase_next = 1'b0;
            if (bit_reg == BIT_LAST) begin
              state_next = HOLD;
            end else begin
              bit_next   = bit_reg + 1'b1;
              frame_next = {frame_reg[FRAME-2:0], 1'b0};
            end
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      HOLD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          state_next = DONE;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      DONE: begin
        div_next   = '0;
        state_next = GAP;
      end
      GAP: begin
        if (div_reg == GAP_LAST) begin
          div_next   = '0;
          state_next = IDLE;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered pins and response; reset forces the idle pin levels immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      sclk_pin  <= (state_reg == SHIFT) && phase_reg;
      cs_pin    <= !((state_reg == SHIFT) || (state_reg == HOLD));
      mosi_pin  <= (state_reg == SHIFT) && frame_reg[FRAME-1];
      rsp_valid <= (state_reg == DONE);
      rsp_rdata <= ((state_reg == DONE) && rw_reg) ? rdata_reg : '0;
    end
  end

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic miso_s1_reg, miso_s2_reg;
  logic cap_d1_reg, cap_d2_reg;

  // Synchronise miso and delay the capture strobe by the same two clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_s1_reg <= 1'b0;
      miso_s2_reg <= 1'b0;
      cap_d1_reg  <= 1'b0;
      cap_d2_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      miso_s1_reg <= miso_pin;
      miso_s2_reg <= miso_s1_reg;
      cap_d1_reg  <= cap_now;
      cap_d2_reg  <= cap_d1_reg;
      if (cap_d2_reg) begin
        rdata_reg <= {rdata_reg[DATA_W-2:0], miso_s2_reg};
      end
    end
  end
`else
  // Capture miso directly in the first sclk-high cycle of each data bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (cap_now) begin
      rdata_reg <= {rdata_reg[DATA_W-2:0], miso_pin};
    end
  end
`endif

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: table-driven check of spi_mem_master against a
// behavioural spiMemory-style slave, plus back-to-back and reset sequences.
module tb_spi_mem_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       sclk_pin, cs_pin, mosi_pin, miso_pin;

  spi_mem_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin), .miso_pin(miso_pin)
  );

  always #5 clk = ~clk;

  // ---------------- slave model and monitors ----------------
  logic [7:0]  mem [0:127];
  logic        clr_req = 1'b0, pre_req = 1'b0;
  logic [6:0]  pre_addr = '0;
  logic [7:0]  pre_val = '0;
  int          tie_mode = 0;              // 0 = slave drives, 1 = tied high, 2 = tied low
  logic        miso_model = 1'b0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [15:0] s_shift = '0, last_frame = '0;
  logic [4:0]  s_cnt = '0, last_cnt = '0;
  logic        s_rw = 1'b0;
  logic [7:0]  s_out = '0;
  int          cyc = 0, acc_cyc = 0, acc_cnt = 0, rsp_cyc = 0, rsp_cnt = 0, csf_cyc = 0;
  int          hi_run = 0, min_gap = 1000, edge_err = 0;
  logic        seen_frame = 1'b0;

  assign miso_pin = (tie_mode == 1) ? 1'b1 : (tie_mode == 2) ? 1'b0 : miso_model;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cyc <= cyc + 1;
      acc_cnt <= acc_cnt + 1;
    end
  end

  always @(negedge clk) begin
    prev_cs   <= cs_pin;
    prev_sclk <= sclk_pin;
    if (clr_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      miso_model <= 1'b0;
    end
    if (pre_req) mem[pre_addr] <= pre_val;
    if (!cs_pin && prev_cs) begin
      s_cnt   <= '0;
      s_shift <= '0;
      s_rw    <= 1'b0;
      csf_cyc <= cyc;
      if (seen_frame && hi_run < min_gap) min_gap <= hi_run;
      seen_frame <= 1'b1;
    end else if (!cs_pin) begin
      if (sclk_pin && !prev_sclk) begin
        s_shift <= {s_shift[14:0], mosi_pin};
        s_cnt   <= s_cnt + 5'd1;
        if (s_cnt == 5'd7) begin
          s_rw  <= mosi_pin;
          s_out <= mem[s_shift[6:0]];
        end
      end
      if (!sclk_pin && prev_sclk && s_rw && s_cnt >= 5'd8 && s_cnt < 5'd16)
        miso_model <= s_out[3'(5'd15 - s_cnt)];
    end
    if (cs_pin && !prev_cs) begin
      last_frame <= s_shift;
      last_cnt   <= s_cnt;
      if (s_cnt == 5'd16 && !s_rw) mem[s_shift[15:9]] <= s_shift[7:0];
    end
    hi_run <= cs_pin ? hi_run + 1 : 0;
    if (cs_pin && prev_cs && (sclk_pin != prev_sclk)) edge_err <= edge_err + 1;
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
    end
  end

  // ---------------- checking helpers ----------------
  int pass_cnt = 0, chk_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 400) begin tick(); n++; end
    chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one command, then scramble the inputs the cycle after accept.
  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
    wait_ready();
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~addr; cmd_wdata = ~wdata;
  endtask

  task automatic wait_rsp(output logic [7:0] rd);
    int n = 0;
    while (!rsp_valid && n < 300) begin tick(); n++; end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    tick();
    chk("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        pre_en;
    logic [7:0]  pre_val;
    int          tie;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] rd;
    int a0, a2, r1, r0, n;

    vecs[0] = '{1'b0, 7'h01, 8'hFF, 1'b0, 8'h00, 0, 16'h02FF, 8'h00};
    vecs[1] = '{1'b1, 7'h01, 8'h00, 1'b0, 8'h00, 0, 16'h0300, 8'hFF};
    vecs[2] = '{1'b1, 7'h01, 8'h00, 1'b1, 8'hA5, 0, 16'h0300, 8'hA5};
    vecs[3] = '{1'b0, 7'h55, 8'h3C, 1'b0, 8'h00, 0, 16'hAA3C, 8'h00};
    vecs[4] = '{1'b1, 7'h55, 8'h00, 1'b0, 8'h00, 0, 16'hAB00, 8'h3C};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 1'b1, 8'h5A, 1, 16'hFF00, 8'hFF};
    vecs[6] = '{1'b1, 7'h7F, 8'h00, 1'b0, 8'h00, 2, 16'hFF00, 8'h00};

    // Reset state
    #1 reset = 1'b1;
    clr_req = 1'b1;
    tick();
    tick();
    clr_req = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cs", {31'd0, cs_pin}, 32'd1);
    chk("rst_sclk", {31'd0, sclk_pin}, 32'd0);
    chk("rst_mosi", {31'd0, mosi_pin}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // Table of single transactions
    for (int v = 0; v < 7; v++) begin
      tie_mode = vecs[v].tie;
      if (vecs[v].pre_en) begin
        pre_addr = vecs[v].addr; pre_val = vecs[v].pre_val; pre_req = 1'b1;
        tick();
        pre_req = 1'b0;
      end
      send(vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      wait_rsp(rd);
      $display("vec %0d rw=%0d addr=%02h frame=%04h rise=%0d rdata=%02h lat=%0d",
               v, vecs[v].rw, vecs[v].addr, last_frame, last_cnt, rd, rsp_cyc - acc_cyc);
      chk("latency", rsp_cyc - acc_cyc, 32'd133);
      chk("cs_fall_offset", csf_cyc - acc_cyc, 32'd1);
      chk("rdata", {24'd0, rd}, {24'd0, vecs[v].exp_rdata});
      chk("mosi_frame", {16'd0, last_frame}, {16'd0, vecs[v].exp_frame});
      chk("sclk_rises", {27'd0, last_cnt}, 32'd16);
      if (!vecs[v].rw) chk("slave_mem", {24'd0, mem[vecs[v].addr]}, {24'd0, vecs[v].wdata});
    end
    tie_mode = 0;

    // Back-to-back with cmd_valid held high
    wait_ready();
    a0 = acc_cnt;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h20; cmd_wdata = 8'h77;
    n = 0;
    while (acc_cnt == a0 && n < 400) begin tick(); n++; end
    cmd_addr = 7'h21; cmd_wdata = 8'h88;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 400) begin tick(); n++; end
    chk("b2b_accepts", acc_cnt - a0, 32'd2);
    a2 = acc_cyc;
    r1 = rsp_cyc;
    cmd_valid = 1'b0;
    chk("b2b_rsp_to_accept", a2 - r1, 32'd8);
    wait_rsp(rd);
    $display("b2b second_accept-first_rsp=%0d min_cs_gap=%0d", a2 - r1, min_gap);
    chk("b2b_mem20", {24'd0, mem[7'h20]}, 32'h77);
    chk("b2b_mem21", {24'd0, mem[7'h21]}, 32'h88);
    chk("cs_gap_ge_8", {31'd0, (min_gap >= 8)}, 32'd1);
    chk("no_sclk_while_cs_high", edge_err, 32'd0);

    // Asynchronous reset after 5 bits of a write
    pre_addr = 7'h10; pre_val = 8'h11; pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
    send(1'b0, 7'h10, 8'h99);
    n = 0;
    while (s_cnt != 5'd5 && n < 200) begin tick(); n++; end
    chk("abort_reached_bit5", {27'd0, s_cnt}, 32'd5);
    r0 = rsp_cnt;
    #2 reset = 1'b1;
    #1;
    chk("abort_cs_async", {31'd0, cs_pin}, 32'd1);
    chk("abort_sclk_async", {31'd0, sclk_pin}, 32'd0);
    chk("abort_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("abort_ready_release", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 150; i++) tick();
    $display("abort rise=%0d rsp_delta=%0d mem10=%02h", last_cnt, rsp_cnt - r0, mem[7'h10]);
    chk("abort_no_rsp", rsp_cnt - r0, 32'd0);
    chk("abort_rises", {27'd0, last_cnt}, 32'd5);
    chk("abort_mem_kept", {24'd0, mem[7'h10]}, 32'h11);
    send(1'b0, 7'h10, 8'h99);
    wait_rsp(rd);
    $display("post-abort frame=%04h rise=%0d", last_frame, last_cnt);
    chk("post_abort_frame", {16'd0, last_frame}, 32'h2099);
    chk("post_abort_rises", {27'd0, last_cnt}, 32'd16);
    chk("post_abort_mem", {24'd0, mem[7'h10]}, 32'h99);
    chk("post_abort_latency", rsp_cyc - acc_cyc, 32'd133);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
